// File: rtl/mdu_issue_ctrl_if.sv
// Bundle of EX-stage, MDU and result signals seen by the MDU issue sequencer.
//
// Handshake semantics: an EX instruction is offered while ex_valid_i is high
// and is held stable by the pipeline for as long as ex_stall_o is high. A result
// is presented with res_valid_o and is held, unchanged, until the pipeline
// reports pipe_advance_i (or kills it with flush_i). The MDU side is a
// fire-and-wait protocol: mdu_start_o pulses for one cycle with operands held on
// mdu_op_o/mdu_a_o/mdu_b_o, and mdu_done_i pulses once with mdu_result_i.
interface mdu_issue_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            ex_valid_i;
    logic [1:0]      chip_select_i;
    logic [2:0]      mdu_op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            pipe_advance_i;
    logic            flush_i;
    logic            mdu_start_o;
    logic [2:0]      mdu_op_o;
    logic [XLEN-1:0] mdu_a_o;
    logic [XLEN-1:0] mdu_b_o;
    logic            mdu_done_i;
    logic [XLEN-1:0] mdu_result_i;
    logic            ex_stall_o;
    logic            res_valid_o;
    logic [XLEN-1:0] res_o;
    logic            timeout_o;
    logic [1:0]      dbg_state_o;   // 0 IDLE, 1 BUSY, 2 DONE, 3 DRAIN

    // Sequencer side.
    modport slave (
        input  ex_valid_i, chip_select_i, mdu_op_i, rs1_i, rs2_i,
        input  pipe_advance_i, flush_i, mdu_done_i, mdu_result_i,
        output mdu_start_o, mdu_op_o, mdu_a_o, mdu_b_o,
        output ex_stall_o, res_valid_o, res_o, timeout_o, dbg_state_o
    );

    // Pipeline / MDU side.
    modport master (
        output ex_valid_i, chip_select_i, mdu_op_i, rs1_i, rs2_i,
        output pipe_advance_i, flush_i, mdu_done_i, mdu_result_i,
        input  mdu_start_o, mdu_op_o, mdu_a_o, mdu_b_o,
        input  ex_stall_o, res_valid_o, res_o, timeout_o, dbg_state_o
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// EX-stage sequencer for the multi-cycle multiply/divide unit.
// Latches operands, pulses the MDU start, stalls EX until a result exists and
// holds it until the pipeline advances. RV32M divide corner cases are answered
// locally without touching the MDU. Flushed operations are drained, and a
// watchdog turns an MDU hang into a zero result plus a sticky flag.
module mdu_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    mdu_issue_ctrl_if.slave bus
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_start;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_res;
    logic            r_timeout;
    logic [WD_W-1:0] r_wd;

    logic            w_req;
    logic            w_rs2_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_wd_expire;
    logic            w_accept;
    logic            w_busy_done;
    logic            w_busy_expire;
    logic            w_drain_expire;
    logic            w_enter_wd;
    logic            w_stall;
    logic            w_res_valid;

    assign w_req       = bus.ex_valid_i && (bus.chip_select_i == 2'b01) && !bus.flush_i;
    assign w_rs2_zero  = (bus.rs2_i == '0);
    // Signed overflow: most negative value divided by -1.
    assign w_ovf       = (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
    assign w_wd_expire = (r_wd == WD_W'(TIMEOUT - 1));

    // Decode divide corner cases that are answered without the MDU.
    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        case (bus.mdu_op_i)
            OP_DIV: begin
                if (w_rs2_zero) begin
                    w_special     = 1'b1;
                    w_special_res = '1;
                end else if (w_ovf) begin
                    w_special     = 1'b1;
                    w_special_res = bus.rs1_i;
                end
            end
            OP_DIVU: begin
                if (w_rs2_zero) begin
                    w_special     = 1'b1;
                    w_special_res = '1;
                end
            end
            OP_REM: begin
                if (w_rs2_zero) begin
                    w_special     = 1'b1;
                    w_special_res = bus.rs1_i;
                end else if (w_ovf) begin
                    w_special     = 1'b1;
                    w_special_res = '0;
                end
            end
            OP_REMU: begin
                if (w_rs2_zero) begin
                    w_special     = 1'b1;
                    w_special_res = bus.rs1_i;
                end
            end
            default: begin
                w_special     = 1'b0;
                w_special_res = '0;
            end
        endcase
    end

    // Qualified events used by both the FSM and the datapath.
    assign w_accept       = (r_state == S_IDLE) && w_req;
    assign w_busy_done    = (r_state == S_BUSY) && bus.mdu_done_i && !bus.flush_i;
    assign w_busy_expire  = (r_state == S_BUSY) && !bus.mdu_done_i && !bus.flush_i && w_wd_expire;
    assign w_drain_expire = (r_state == S_DRAIN) && !bus.mdu_done_i && w_wd_expire;
    assign w_enter_wd     = ((w_state_nxt == S_BUSY) || (w_state_nxt == S_DRAIN)) &&
                            (w_state_nxt != r_state);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; in BUSY a done beats a flush beats the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) w_state_nxt = w_special ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                if (bus.mdu_done_i)   w_state_nxt = bus.flush_i ? S_IDLE : S_DONE;
                else if (bus.flush_i) w_state_nxt = S_DRAIN;
                else if (w_wd_expire) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.flush_i || bus.pipe_advance_i) w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.mdu_done_i || w_wd_expire) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs: stall while accepting, busy, or holding a new op behind a drain.
    always_comb begin
        w_stall     = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_stall     = w_req;
            S_BUSY:  w_stall     = 1'b1;
            S_DONE:  w_res_valid = 1'b1;
            S_DRAIN: w_stall     = w_req;
            default: begin
                w_stall     = 1'b0;
                w_res_valid = 1'b0;
            end
        endcase
    end

    // Operand latch, start pulse and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            r_start <= w_accept && !w_special;
            if (w_accept) begin
                if (w_special) begin
                    r_res <= w_special_res;
                end else begin
                    r_op <= bus.mdu_op_i;
                    r_a  <= bus.rs1_i;
                    r_b  <= bus.rs2_i;
                end
            end
            if (w_busy_done)        r_res <= bus.mdu_result_i;
            else if (w_busy_expire) r_res <= '0;
        end
    end

    // Watchdog: restarts on BUSY/DRAIN entry, counts while there, flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_enter_wd) begin
                r_wd <= '0;
            end else if ((r_state == S_BUSY) || (r_state == S_DRAIN)) begin
                if (!w_wd_expire) r_wd <= r_wd + 1'b1;
            end
            if (w_busy_expire || w_drain_expire) r_timeout <= 1'b1;
        end
    end

    assign bus.mdu_start_o = r_start;
    assign bus.mdu_op_o    = r_op;
    assign bus.mdu_a_o     = r_a;
    assign bus.mdu_b_o     = r_b;
    assign bus.ex_stall_o  = w_stall;
    assign bus.res_valid_o = w_res_valid;
    assign bus.res_o       = r_res;
    assign bus.timeout_o   = r_timeout;
    assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: a vector table for single operations,
// then hand-written sequences for drain, flush, watchdog and reset corners.
module tb_mdu_issue_ctrl;

    logic clk;
    logic rst;

    mdu_issue_ctrl_if #(.XLEN(32)) bus ();

    mdu_issue_ctrl #(.XLEN(32), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        special;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ex_valid_i     = 1'b0;
        bus.chip_select_i  = 2'b00;
        bus.mdu_op_i       = 3'b000;
        bus.rs1_i          = '0;
        bus.rs2_i          = '0;
        bus.pipe_advance_i = 1'b0;
        bus.flush_i        = 1'b0;
        bus.mdu_done_i     = 1'b0;
        bus.mdu_result_i   = '0;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.ex_valid_i    = 1'b1;
        bus.chip_select_i = 2'b01;
        bus.mdu_op_i      = op;
        bus.rs1_i         = a;
        bus.rs2_i         = b;
    endtask

    // Pulse pipe_advance in DONE and check the FSM returns to IDLE.
    task automatic advance(input string tag);
        bus.pipe_advance_i = 1'b1;
        tick();
        bus.pipe_advance_i = 1'b0;
        bus.ex_valid_i     = 1'b0;
        #1;
        chk({tag, "_after_adv_valid"}, 32'(bus.res_valid_o), 32'd0);
        chk({tag, "_after_adv_state"}, 32'(bus.dbg_state_o), 32'd0);
    endtask

    // One table entry from acceptance to pipe advance.
    task automatic run_vec(input int idx);
        vec_t  v;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("vec%0d", idx);
        drive_req(v.op, v.a, v.b);
        #1;
        chk({tag, "_accept_stall"}, 32'(bus.ex_stall_o), 32'd1);
        chk({tag, "_accept_start"}, 32'(bus.mdu_start_o), 32'd0);
        exp_q.push_back(v.exp);
        tick();
        if (v.special) begin
            chk({tag, "_spec_start"}, 32'(bus.mdu_start_o), 32'd0);
        end else begin
            chk({tag, "_start"}, 32'(bus.mdu_start_o), 32'd1);
            chk({tag, "_mdu_op"}, 32'(bus.mdu_op_o), 32'(v.op));
            chk({tag, "_mdu_a"}, bus.mdu_a_o, v.a);
            chk({tag, "_mdu_b"}, bus.mdu_b_o, v.b);
            for (int j = 0; j <= v.lat; j++) begin
                if (j > 0) chk({tag, "_start_once"}, 32'(bus.mdu_start_o), 32'd0);
                if (j == v.lat) begin
                    bus.mdu_done_i   = 1'b1;
                    bus.mdu_result_i = v.exp;
                end
                #1;
                chk({tag, "_busy_stall"}, 32'(bus.ex_stall_o), 32'd1);
                tick();
                bus.mdu_done_i   = 1'b0;
                bus.mdu_result_i = 32'hBAD0_BAD0;
            end
        end
        #1;
        chk({tag, "_res_valid"}, 32'(bus.res_valid_o), 32'd1);
        chk({tag, "_done_stall"}, 32'(bus.ex_stall_o), 32'd0);
        chk({tag, "_res"}, bus.res_o, exp_q.pop_front());
        advance(tag);
    endtask

    initial begin
        // vector table: op, rs1, rs2, special, latency, expected result
        vecs[0] = '{3'b100, 32'd100,       32'd0,        1'b1, 0, 32'hFFFF_FFFF}; // DIV /0
        vecs[1] = '{3'b111, 32'd5,         32'd0,        1'b1, 0, 32'h0000_0005}; // REMU /0
        vecs[2] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000}; // DIV ovf
        vecs[3] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h0000_0000}; // REM ovf
        vecs[4] = '{3'b101, 32'd7,         32'd0,        1'b1, 0, 32'hFFFF_FFFF}; // DIVU /0
        vecs[5] = '{3'b110, 32'd9,         32'd0,        1'b1, 0, 32'h0000_0009}; // REM /0
        vecs[6] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 32'h0000_0000}; // DIVU not special
        vecs[7] = '{3'b100, 32'd100,       32'd7,        1'b0, 2, 32'd14};        // DIV
        vecs[8] = '{3'b011, 32'hFFFF_FFFF, 32'd2,        1'b0, 0, 32'h0000_0001}; // MULHU
        vecs[9] = '{3'b110, 32'h8000_0000, 32'd1,        1'b0, 3, 32'h0000_0000}; // REM not ovf

        // reset
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(bus.dbg_state_o), 32'd0);
        chk("rst_start", 32'(bus.mdu_start_o), 32'd0);
        chk("rst_stall", 32'(bus.ex_stall_o), 32'd0);
        chk("rst_valid", 32'(bus.res_valid_o), 32'd0);
        chk("rst_res", bus.res_o, 32'd0);
        chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
        chk("rst_mdu_a", bus.mdu_a_o, 32'd0);

        // non-MDU instruction in IDLE never stalls
        bus.ex_valid_i    = 1'b1;
        bus.chip_select_i = 2'b10;
        #1;
        chk("nonmdu_idle_stall", 32'(bus.ex_stall_o), 32'd0);
        bus.ex_valid_i    = 1'b0;

        // MUL 7*6, done 2 cycles after start; count stall cycles; hold result 3 cycles
        begin
            int stalls;
            stalls = 0;
            drive_req(3'b000, 32'd7, 32'd6);
            #1;
            if (bus.ex_stall_o) stalls++;
            tick();
            chk("mul_start", 32'(bus.mdu_start_o), 32'd1);
            chk("mul_a", bus.mdu_a_o, 32'd7);
            chk("mul_b", bus.mdu_b_o, 32'd6);
            if (bus.ex_stall_o) stalls++;
            tick();
            chk("mul_start_once", 32'(bus.mdu_start_o), 32'd0);
            if (bus.ex_stall_o) stalls++;
            tick();
            bus.mdu_done_i   = 1'b1;
            bus.mdu_result_i = 32'd42;
            #1;
            if (bus.ex_stall_o) stalls++;
            tick();
            bus.mdu_done_i   = 1'b0;
            bus.mdu_result_i = 32'd0;
            #1;
            chk("mul_stall_cycles", 32'(stalls), 32'd4);
            for (int i = 0; i < 3; i++) begin
                chk("mul_hold_valid", 32'(bus.res_valid_o), 32'd1);
                chk("mul_hold_res", bus.res_o, 32'd42);
                chk("mul_hold_stall", 32'(bus.ex_stall_o), 32'd0);
                tick();
            end
            advance("mul");
        end

        // table-driven single operations
        for (int i = 0; i < 10; i++) run_vec(i);

        // flush two cycles into BUSY, drain, then a queued MDU op starts
        drive_req(3'b000, 32'd11, 32'd13);
        #1;
        chk("fl_accept_stall", 32'(bus.ex_stall_o), 32'd1);
        tick();
        chk("fl_start", 32'(bus.mdu_start_o), 32'd1);
        tick();
        bus.flush_i    = 1'b1;
        bus.ex_valid_i = 1'b0;
        #1;
        chk("fl_busy_stall", 32'(bus.ex_stall_o), 32'd1);
        tick();
        bus.flush_i       = 1'b0;
        bus.ex_valid_i    = 1'b1;
        bus.chip_select_i = 2'b10;
        #1;
        chk("fl_drain_state", 32'(bus.dbg_state_o), 32'd3);
        chk("fl_drain_nonmdu_stall", 32'(bus.ex_stall_o), 32'd0);
        drive_req(3'b000, 32'd3, 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus.mdu_done_i   = 1'b1;
                bus.mdu_result_i = 32'hDEAD_BEEF;
            end
            #1;
            chk("fl_drain_stall", 32'(bus.ex_stall_o), 32'd1);
            chk("fl_drain_nostart", 32'(bus.mdu_start_o), 32'd0);
            tick();
        end
        bus.mdu_done_i   = 1'b0;
        bus.mdu_result_i = '0;
        #1;
        chk("fl_idle_state", 32'(bus.dbg_state_o), 32'd0);
        chk("fl_discard_valid", 32'(bus.res_valid_o), 32'd0);
        chk("fl_reaccept_stall", 32'(bus.ex_stall_o), 32'd1);
        tick();
        chk("fl_restart", 32'(bus.mdu_start_o), 32'd1);
        chk("fl_restart_a", bus.mdu_a_o, 32'd3);
        bus.mdu_done_i   = 1'b1;
        bus.mdu_result_i = 32'd15;
        tick();
        bus.mdu_done_i   = 1'b0;
        #1;
        chk("fl_res_valid", 32'(bus.res_valid_o), 32'd1);
        chk("fl_res", bus.res_o, 32'd15);
        advance("fl");

        // flush and done in the same BUSY cycle: result dropped, back to IDLE
        drive_req(3'b000, 32'd2, 32'd2);
        tick();
        bus.mdu_done_i   = 1'b1;
        bus.mdu_result_i = 32'd4;
        bus.flush_i      = 1'b1;
        bus.ex_valid_i   = 1'b0;
        tick();
        bus.mdu_done_i = 1'b0;
        bus.flush_i    = 1'b0;
        #1;
        chk("fd_state", 32'(bus.dbg_state_o), 32'd0);
        chk("fd_valid", 32'(bus.res_valid_o), 32'd0);
        chk("fd_res_kept", bus.res_o, 32'd15);

        // flush in DONE together with advance
        drive_req(3'b100, 32'd1, 32'd0);
        tick();
        chk("dfl_valid", 32'(bus.res_valid_o), 32'd1);
        bus.flush_i        = 1'b1;
        bus.pipe_advance_i = 1'b1;
        bus.ex_valid_i     = 1'b0;
        tick();
        bus.flush_i        = 1'b0;
        bus.pipe_advance_i = 1'b0;
        #1;
        chk("dfl_valid_drop", 32'(bus.res_valid_o), 32'd0);
        chk("dfl_state", 32'(bus.dbg_state_o), 32'd0);

        // stray done in IDLE is ignored
        bus.mdu_done_i   = 1'b1;
        bus.mdu_result_i = 32'h0000_1234;
        tick();
        bus.mdu_done_i   = 1'b0;
        #1;
        chk("stray_valid", 32'(bus.res_valid_o), 32'd0);
        chk("stray_res", bus.res_o, 32'hFFFF_FFFF);

        // watchdog: MDU never answers
        drive_req(3'b000, 32'd9, 32'd9);
        tick();
        for (int i = 1; i < 64; i++) tick();
        chk("wd_before_flag", 32'(bus.timeout_o), 32'd0);
        chk("wd_before_stall", 32'(bus.ex_stall_o), 32'd1);
        tick();
        chk("wd_flag", 32'(bus.timeout_o), 32'd1);
        chk("wd_state", 32'(bus.dbg_state_o), 32'd2);
        chk("wd_valid", 32'(bus.res_valid_o), 32'd1);
        chk("wd_res", bus.res_o, 32'd0);
        chk("wd_stall", 32'(bus.ex_stall_o), 32'd0);
        advance("wd");
        chk("wd_sticky", 32'(bus.timeout_o), 32'd1);

        // reset while BUSY
        drive_req(3'b001, 32'h55, 32'h66);
        tick();
        chk("rb_start", 32'(bus.mdu_start_o), 32'd1);
        rst            = 1'b1;
        bus.ex_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rb_state", 32'(bus.dbg_state_o), 32'd0);
        chk("rb_start0", 32'(bus.mdu_start_o), 32'd0);
        chk("rb_op", 32'(bus.mdu_op_o), 32'd0);
        chk("rb_a", bus.mdu_a_o, 32'd0);
        chk("rb_b", bus.mdu_b_o, 32'd0);
        chk("rb_stall", 32'(bus.ex_stall_o), 32'd0);
        chk("rb_valid", 32'(bus.res_valid_o), 32'd0);
        chk("rb_timeout", 32'(bus.timeout_o), 32'd0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
